prbs_rx_checker: RTL and testbench
==================================

PRBS_RX_CHECKER -- requirements
Module: prbs_rx_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 64: parallel word width; legal range 32..128.
REQ-002 SHALL have parameter LOCK_CNT, default 16: consecutive clean checked words needed to lock.
REQ-003 SHALL have parameter LOSS_CNT, default 4: consecutive errored words that drop lock.
REQ-004 SHALL have parameter CNT_W, default 32: width of err_count and word_count.
REQ-005 SHALL have port clk_100_clk, input, 1: single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_100_reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port rx_data, input, DATA_W: received word; bit 0 is the earliest serial bit.
REQ-008 SHALL have port rx_valid, input, 1: rx_data is qualified this cycle.
REQ-009 SHALL have port invert, input, 1: invert rx_data before checking.
REQ-010 SHALL have port clear, input, 1: synchronous clear of err_count, word_count and loss_count.
REQ-011 SHALL have port locked, output, 1: checker is in state LOCKED.
REQ-012 SHALL have port err_word, output, 1: one-cycle pulse for each checked word with an error.
REQ-013 SHALL have port err_count, output, CNT_W: saturating error count.
REQ-014 SHALL have port word_count, output, CNT_W: saturating count of words checked while locked.
REQ-015 SHALL have port loss_count, output, 8: saturating count of LOCKED-to-SEARCH transitions.

Function
REQ-016 SHALL check PRBS31 (x^31+x^28+1) self-synchronously: with s = {current word, previous valid word}, expected bit i = s[i-31] XOR s[i-28], and mismatch vector = expected XOR received.
REQ-017 SHALL leave the first valid word after reset, or after entering SEARCH, unchecked; that word only loads the previous-word register.
REQ-018 SHALL treat an all-zero word (after inversion) as errored, with all DATA_W bits marked in error, because PRBS31 cannot produce it.
REQ-019 SHALL ignore cycles with rx_valid=0: no state, counter or previous-word change.
REQ-020 SHALL pulse err_word high for one cycle, one cycle after the edge that sampled the errored word.
REQ-021 SHALL update locked and the counters one edge after err_word (two-cycle latency from sampling).
REQ-022 SHALL implement FSM state SEARCH: a clean checked word increments good_run; an errored word zeroes good_run; when good_run reaches LOCK_CNT, go to LOCKED and zero bad_run.
REQ-023 SHALL implement FSM state LOCKED: an errored word increments bad_run; a clean word zeroes bad_run; when bad_run reaches LOSS_CNT, go to SEARCH, increment loss_count and invalidate the previous word.
REQ-024 SHALL update word_count and err_count only in LOCKED, including on the word that causes the loss of lock.
REQ-025 SHALL saturate all counters at all-ones; they SHALL NOT wrap.
REQ-026 SHALL give clear priority over a same-cycle increment, so counters read 0 the next cycle; clear SHALL NOT change FSM state.
REQ-027 SHALL apply a change of invert from the next valid word onward; the word in flight is not re-evaluated.

Reset
REQ-028 SHALL, on reset_100_reset_n low, asynchronously force: state SEARCH, good_run and bad_run 0, previous word invalid, locked 0, err_word 0, all counters 0.
REQ-029 SHALL discard any pipeline content when reset is asserted mid-operation; release is synchronous to clk_100_clk.

Configuration
REQ-030 SHALL, with PRBS_CHK_BIT_COUNT_EN defined, add popcount(mismatch vector) to err_count for each errored word.
REQ-031 SHALL, without PRBS_CHK_BIT_COUNT_EN, add 1 to err_count per errored word and omit the popcount logic.

Verification
REQ-032 Reset, then 20 clean PRBS31 words back-to-back -> locked rises 2 cycles after the 17th word is sampled; err_count=0; word_count=3.
REQ-033 While locked, flip bit 5 of one word -> single err_word pulse; err_count +3 with the macro defined, +1 without; locked stays 1.
REQ-034 While locked, 4 consecutive all-zero words -> locked falls; loss_count=1; err_count +256 with the macro defined (DATA_W=64).
REQ-035 invert=1 with an inverted stream -> locks after 17 words; same stream with invert=0 -> locked never rises within 100 words.
REQ-036 Assert clear in the same cycle an errored word updates the counters -> err_count, word_count and loss_count read 0 on the next cycle; locked unchanged.
REQ-037 Assert reset_100_reset_n low mid-lock, off a clock edge -> all outputs 0 immediately; after release, relock requires 17 fresh words.

Source files
------------

// File: rtl/prbs_rx_checker.sv
// Self-synchronising PRBS31 receive checker with SEARCH/LOCKED tracking and saturating counters.
// Optional: define PRBS_CHK_BIT_COUNT_EN so err_count accumulates errored bits instead of errored words.
module prbs_rx_checker #(
    parameter int DATA_W   = 64,
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk_100_clk,
    input  logic              reset_100_reset_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              invert,
    input  logic              clear,
    output logic              locked,
    output logic              err_word,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  word_count,
    output logic [7:0]        loss_count
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);
`ifdef PRBS_CHK_BIT_COUNT_EN
    localparam int PW = $clog2(DATA_W + 1);
`endif
    localparam logic [GW-1:0] LOCK_TGT = GW'(LOCK_CNT);
    localparam logic [BW-1:0] LOSS_TGT = BW'(LOSS_CNT);

    typedef enum logic [0:0] {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

`ifdef PRBS_CHK_BIT_COUNT_EN
    function automatic logic [PW-1:0] popcount(input logic [DATA_W-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_W; i++) n = n + PW'(v[i]);
        return n;
    endfunction
`endif

    logic [DATA_W-1:0] w_cur;
    logic [DATA_W-1:0] w_exp;
    logic [DATA_W-1:0] w_mis;
    logic [CNT_W-1:0]  w_err_inc;
    state_t            w_state_n;
    logic [GW-1:0]     w_good_n;
    logic [BW-1:0]     w_bad_n;
    logic              w_lose;

    // Only the top 31 bits of the previous word feed the recurrence.
    logic [30:0]       r_last;
    logic              r_last_vld;
    logic              r_chk_p0;
    logic [DATA_W-1:0] r_mis_p0;
    logic              r_vld_p1;
    logic              r_err_p1;
`ifdef PRBS_CHK_BIT_COUNT_EN
    logic [PW-1:0]     r_pop_p1;
`endif
    state_t            r_state;
    logic [GW-1:0]     r_good;
    logic [BW-1:0]     r_bad;
    logic [CNT_W-1:0]  r_err_count;
    logic [CNT_W-1:0]  r_word_count;
    logic [7:0]        r_loss_count;

    assign w_cur = rx_data ^ {DATA_W{invert}};
    assign w_exp = {w_cur[DATA_W-32:0], r_last} ^ {w_cur[DATA_W-29:0], r_last[30:3]};
    // An all-zero word is unreachable for PRBS31, so every bit is flagged.
    assign w_mis = (w_cur == '0) ? {DATA_W{1'b1}} : (w_exp ^ w_cur);

    // Stage p0: sample word, compare against previous-word recurrence
    always_ff @(posedge clk_100_clk or negedge reset_100_reset_n) begin
        if (!reset_100_reset_n) begin
            r_last_vld <= 1'b0;
            r_chk_p0   <= 1'b0;
        end else begin
            r_chk_p0 <= rx_valid & r_last_vld;
            if (w_lose)        r_last_vld <= 1'b0;
            else if (rx_valid) r_last_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk_100_clk) begin
        if (rx_valid) begin
            r_last   <= w_cur[DATA_W-1:DATA_W-31];
            r_mis_p0 <= w_mis;
        end
    end

    // Stage p1: reduce mismatch vector to an error flag (and bit count)
    always_ff @(posedge clk_100_clk or negedge reset_100_reset_n) begin
        if (!reset_100_reset_n) begin
            r_vld_p1 <= 1'b0;
            r_err_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= r_chk_p0;
            r_err_p1 <= r_chk_p0 & (|r_mis_p0);
        end
    end

`ifdef PRBS_CHK_BIT_COUNT_EN
    always_ff @(posedge clk_100_clk) begin
        r_pop_p1 <= popcount(r_mis_p0);
    end
    assign w_err_inc = CNT_W'(r_pop_p1);
`else
    assign w_err_inc = CNT_W'(1);
`endif

    // Stage p2: lock FSM and counters
    always_comb begin
        w_state_n = r_state;
        w_good_n  = r_good;
        w_bad_n   = r_bad;
        w_lose    = 1'b0;
        if (r_vld_p1) begin
            case (r_state)
                ST_SEARCH: begin
                    if (r_err_p1) begin
                        w_good_n = '0;
                    end else if (r_good + GW'(1) == LOCK_TGT) begin
                        w_state_n = ST_LOCKED;
                        w_good_n  = '0;
                        w_bad_n   = '0;
                    end else begin
                        w_good_n = r_good + GW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!r_err_p1) begin
                        w_bad_n = '0;
                    end else if (r_bad + BW'(1) == LOSS_TGT) begin
                        w_state_n = ST_SEARCH;
                        w_good_n  = '0;
                        w_bad_n   = '0;
                        w_lose    = 1'b1;
                    end else begin
                        w_bad_n = r_bad + BW'(1);
                    end
                end
                default: w_state_n = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_100_clk or negedge reset_100_reset_n) begin
        if (!reset_100_reset_n) begin
            r_state <= ST_SEARCH;
            r_good  <= '0;
            r_bad   <= '0;
        end else begin
            r_state <= w_state_n;
            r_good  <= w_good_n;
            r_bad   <= w_bad_n;
        end
    end

    always_ff @(posedge clk_100_clk or negedge reset_100_reset_n) begin
        if (!reset_100_reset_n) begin
            r_err_count  <= '0;
            r_word_count <= '0;
            r_loss_count <= '0;
        end else if (clear) begin
            r_err_count  <= '0;
            r_word_count <= '0;
            r_loss_count <= '0;
        end else begin
            if (r_vld_p1 && (r_state == ST_LOCKED)) begin
                r_word_count <= sat_add(r_word_count, CNT_W'(1));
                if (r_err_p1) r_err_count <= sat_add(r_err_count, w_err_inc);
            end
            if (w_lose && (r_loss_count != 8'hFF)) r_loss_count <= r_loss_count + 8'd1;
        end
    end

    assign locked     = (r_state == ST_LOCKED);
    assign err_word   = r_err_p1;
    assign err_count  = r_err_count;
    assign word_count = r_word_count;
    assign loss_count = r_loss_count;

endmodule

// File: tb/tb_prbs_rx_checker.sv
// Bench for prbs_rx_checker: directed vector table and sequences plus randomized traffic vs a reference model.
module tb_prbs_rx_checker;
    localparam int W    = 64;
    localparam int LOCK = 16;
    localparam int LOSS = 4;
    localparam int CW   = 10;
    localparam longint MAXC = (64'd1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [W-1:0]  rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          invert = 1'b0;
    logic          clear = 1'b0;
    logic          locked, err_word;
    logic [CW-1:0] err_count, word_count;
    logic [7:0]    loss_count;

    always #5 clk = ~clk;

    prbs_rx_checker #(.DATA_W(W), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CNT_W(CW)) dut (
        .clk_100_clk(clk), .reset_100_reset_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .invert(invert), .clear(clear), .locked(locked), .err_word(err_word),
        .err_count(err_count), .word_count(word_count), .loss_count(loss_count));

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // PRBS31 source: serial bits, b[n] = b[n-31] ^ b[n-28], bit 0 of a word is earliest.
    bit gq[$];
    task automatic seed_gen();
        gq.delete();
        for (int i = 0; i < 31; i++) gq.push_back(bit'($urandom_range(0, 1)));
        gq[0] = 1'b1;
    endtask
    task automatic gen(output logic [W-1:0] w);
        bit b;
        for (int i = 0; i < W; i++) begin
            b = gq[0] ^ gq[3];
            w[i] = b;
            gq.push_back(b);
            void'(gq.pop_front());
        end
    endtask

    // Reference model: per-word rules, results surface to the lock logic two edges later.
    typedef struct { bit chk; bit err; int bits; } res_t;
    res_t         m_d1, m_d2;
    logic [W-1:0] m_prev;
    bit           m_prev_vld, m_locked;
    int           m_good, m_bad;
    longint       m_err, m_word, m_loss;

    function automatic int bit_errors(input logic [W-1:0] cur, input logic [W-1:0] prev);
        int  cnt;
        int  k1, k2;
        logic e1, e2;
        if (cur == '0) return W;
        cnt = 0;
        for (int i = 0; i < W; i++) begin
            k1 = i - 31;
            k2 = i - 28;
            e1 = (k1 >= 0) ? cur[k1] : prev[W + k1];
            e2 = (k2 >= 0) ? cur[k2] : prev[W + k2];
            if ((e1 ^ e2) != cur[i]) cnt++;
        end
        return cnt;
    endfunction

    function automatic longint inc_of(input int bits);
`ifdef PRBS_CHK_BIT_COUNT_EN
        return longint'(bits);
`else
        return (bits != 0) ? 64'd1 : 64'd0;
`endif
    endfunction

    function automatic longint sat(input longint x);
        return (x > MAXC) ? MAXC : x;
    endfunction

    task automatic model_reset();
        m_d1 = '{default: 0};
        m_d2 = '{default: 0};
        m_prev = '0;
        m_prev_vld = 0; m_locked = 0; m_good = 0; m_bad = 0;
        m_err = 0; m_word = 0; m_loss = 0;
    endtask

    task automatic model_step(input bit v, input logic [W-1:0] d, input bit inv, input bit clr);
        res_t now;
        logic [W-1:0] cur;
        bit lose;
        lose = 0;
        cur = d ^ {W{inv}};
        now.chk  = v && m_prev_vld;
        now.bits = now.chk ? bit_errors(cur, m_prev) : 0;
        now.err  = now.chk && (now.bits != 0);
        if (m_d2.chk) begin
            if (!m_locked) begin
                if (m_d2.err) m_good = 0;
                else begin
                    m_good++;
                    if (m_good == LOCK) begin m_locked = 1; m_good = 0; m_bad = 0; end
                end
            end else begin
                m_word = sat(m_word + 1);
                if (m_d2.err) begin
                    m_err = sat(m_err + inc_of(m_d2.bits));
                    m_bad++;
                    if (m_bad == LOSS) begin
                        m_locked = 0; m_bad = 0; m_good = 0; lose = 1;
                        m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                    end
                end else m_bad = 0;
            end
        end
        if (clr) begin m_err = 0; m_word = 0; m_loss = 0; end
        m_d2 = m_d1;
        m_d1 = now;
        if (lose) m_prev_vld = 0;
        else if (v) begin m_prev = cur; m_prev_vld = 1; end
    endtask

    task automatic send(input bit v, input logic [W-1:0] d, input bit inv, input bit clr);
        rx_valid = v; rx_data = d; invert = inv; clear = clr;
        model_step(v, d, inv, clr);
        @(posedge clk);
        #1;
        if (err_word === 1'b1) pulses++;
        chk("mdl_locked", locked, m_locked);
        chk("mdl_err_word", err_word, m_d2.err);
        chk("mdl_err_count", err_count, m_err);
        chk("mdl_word_count", word_count, m_word);
        chk("mdl_loss_count", loss_count, m_loss);
    endtask

    task automatic idle(input int n, input bit inv);
        for (int i = 0; i < n; i++) send(1'b0, {$urandom, $urandom}, inv, 1'b0);
    endtask

    task automatic word(input bit inv, input logic [W-1:0] mask);
        logic [W-1:0] w;
        gen(w);
        send(1'b1, (w ^ {W{inv}}) ^ mask, inv, 1'b0);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_err_word", err_word, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_loss_count", loss_count, 0);
        model_reset();
        rx_valid = 1'b0; clear = 1'b0; invert = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic lock_seq(input bit inv);
        for (int k = 1; k <= 20; k++) begin
            word(inv, '0);
            if (k == 17 || k == 18) chk("lock_early", locked, 0);
            if (k == 19) chk("lock_rise", locked, 1);
        end
        idle(2, inv);
        chk("lock_word_count", word_count, 3);
        chk("lock_err_count", err_count, 0);
    endtask

    typedef struct { logic [W-1:0] mask; int npulse; int nbits; } vec_t;
    vec_t tbl[5];

    initial begin
        logic [W-1:0] w;
        bit   inv, v, c, seen;
        int   r, idx, burst;

        tbl[0] = '{mask: 64'd1 << 5,                  npulse: 1, nbits: 3};
        tbl[1] = '{mask: 64'd1 << 0,                  npulse: 1, nbits: 3};
        tbl[2] = '{mask: 64'd1 << 63,                 npulse: 2, nbits: 3};
        tbl[3] = '{mask: 64'd1 << 40,                 npulse: 2, nbits: 3};
        tbl[4] = '{mask: (64'd1 << 5) | (64'd1 << 33), npulse: 2, nbits: 4};

        seed_gen();
        model_reset();
        do_reset();
        lock_seq(1'b0);

        for (int t = 0; t < 5; t++) begin
            do_reset();
            lock_seq(1'b0);
            pulses = 0;
            word(1'b0, tbl[t].mask);
            word(1'b0, '0);
            idle(3, 1'b0);
            chk("tbl_pulses", pulses, tbl[t].npulse);
`ifdef PRBS_CHK_BIT_COUNT_EN
            chk("tbl_err_count", err_count, tbl[t].nbits);
`else
            chk("tbl_err_count", err_count, tbl[t].npulse);
`endif
            chk("tbl_word_count", word_count, 5);
            chk("tbl_locked", locked, 1);
        end

        // Loss of lock on four zero words, then clear racing a counter update.
        do_reset();
        lock_seq(1'b0);
        for (int i = 0; i < 4; i++) send(1'b1, '0, 1'b0, 1'b0);
        idle(4, 1'b0);
        chk("loss_locked", locked, 0);
        chk("loss_count", loss_count, 1);
        chk("loss_word_count", word_count, 7);
`ifdef PRBS_CHK_BIT_COUNT_EN
        chk("loss_err_count", err_count, 256);
`else
        chk("loss_err_count", err_count, 4);
`endif
        for (int i = 0; i < 17; i++) word(1'b0, '0);
        idle(2, 1'b0);
        chk("relock", locked, 1);
        word(1'b0, 64'd1 << 5);
        send(1'b0, '0, 1'b0, 1'b0);
        chk("clr_pulse", err_word, 1);
        send(1'b0, '0, 1'b0, 1'b1);
        chk("clr_err_count", err_count, 0);
        chk("clr_word_count", word_count, 0);
        chk("clr_loss_count", loss_count, 0);
        chk("clr_locked", locked, 1);

        // Inverted stream with and without invert.
        do_reset();
        lock_seq(1'b1);
        do_reset();
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            gen(w);
            send(1'b1, ~w, 1'b0, 1'b0);
            if (locked === 1'b1) seen = 1;
        end
        idle(2, 1'b0);
        chk("noinv_never_locks", seen, 0);

        // Reset mid-lock, then relock needs 17 fresh words.
        do_reset();
        lock_seq(1'b0);
        do_reset();
        for (int i = 0; i < 16; i++) word(1'b0, '0);
        idle(4, 1'b0);
        chk("rst_relock_16", locked, 0);
        word(1'b0, '0);
        idle(2, 1'b0);
        chk("rst_relock_17", locked, 1);

        // Drive every counter into saturation.
        do_reset();
        for (int n = 0; n < 260; n++) begin
            for (int i = 0; i < 17; i++) word(1'b0, '0);
            idle(2, 1'b0);
            for (int i = 0; i < 4; i++) send(1'b1, '0, 1'b0, 1'b0);
            idle(3, 1'b0);
        end
        chk("sat_err_count", err_count, MAXC);
        chk("sat_word_count", word_count, MAXC);
        chk("sat_loss_count", loss_count, 255);

        // Randomized traffic against the model.
        do_reset();
        inv = 0;
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) inv = ~inv;
            c = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 199) == 0) burst = 5;
            if (v) begin
                gen(w);
                w = w ^ {W{inv}};
                r = $urandom_range(0, 99);
                if (burst > 0) begin
                    w = {W{inv}};
                    burst--;
                end else if (r < 3) begin
                    idx = $urandom_range(0, W - 1);
                    w[idx] = ~w[idx];
                end else if (r < 4) begin
                    w = {W{inv}};
                end else if (r < 5) begin
                    w = ~w;
                end
            end else begin
                w = {$urandom, $urandom};
            end
            send(v, w, inv, c);
        end
        idle(3, inv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
